robot_nav: RTL and testbench
============================

ROBOT_NAV -- requirements
Module: robot_nav

Interface
REQ-001 Parameter N_SENS, default 3: number of distance channels (legal range 2..8); channel 0 is front, channels 1..N_SENS-1 are side candidates.
REQ-002 Parameter DW, default 16: width of each distance sample, unsigned.
REQ-003 Parameter D_SLOW, default 400: front distance below which speed drops to slow.
REQ-004 Parameter D_STOP, default 100: distance below which a channel counts as blocked.
REQ-005 Parameter FILT, default 2: consecutive valid samples needed to confirm a blocked or clear front.
REQ-006 Parameter TURN_CYC, default 8: clock cycles spent in TURN.
REQ-007 Parameter WD_CYC, default 64: cycles without dist_valid before the sensor-timeout trip.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rstn  in  1  reset, asynchronous, active-low.
REQ-010 dist_v  in  N_SENS*DW  packed distances; channel k occupies bits [k*DW +: DW].
REQ-011 dist_valid  in  1  single-cycle strobe; dist_v is sampled only when it is high.
REQ-012 speed  out  2  0 = stop, 1 = slow, 2 = fast; value 3 is never driven.
REQ-013 turning  out  1  high while in TURN.
REQ-014 turn_dir  out  clog2(N_SENS)  channel index being turned toward; holds its value outside TURN.
REQ-015 state  out  3  encoded FSM state: IDLE=0, CRUISE=1, SLOW=2, TURN=3, HALT=4.
REQ-016 timeout  out  1  sticky flag, set on a watchdog trip and cleared only by reset.

Function
REQ-017 All outputs are registered; the response to a dist_valid sample appears on the cycle after the strobe.
REQ-018 Blocked test is strict less-than: a distance equal to D_STOP is clear; a front equal to D_SLOW is fast.
REQ-019 blk_cnt counts consecutive valid samples with front < D_STOP, resets to 0 on any clear front sample, and saturates at FILT.
- Front is "confirmed blocked" when blk_cnt == FILT.
REQ-020 clr_cnt counts consecutive valid samples with front >= D_SLOW, resets to 0 otherwise, and saturates at FILT.
REQ-021 IDLE (speed 0): on the first valid sample, move to:
- TURN if front < D_STOP;
- SLOW if front < D_SLOW;
- CRUISE otherwise.
REQ-022 IDLE ignores FILT for its first decision.
REQ-023 CRUISE (speed 2), on a valid sample:
- confirmed blocked -> TURN;
- else front < D_SLOW -> SLOW.
REQ-024 SLOW (speed 1), on a valid sample:
- confirmed blocked -> TURN;
- else front >= D_SLOW -> CRUISE.
REQ-025 On TURN entry, turn_dir latches the side channel with the largest distance; on a tie the lowest index wins.
REQ-026 If every side channel is < D_STOP at TURN entry, the FSM goes to HALT instead of TURN, and turn_dir is unchanged.
REQ-027 TURN (speed 0, turning 1) lasts exactly TURN_CYC cycles regardless of samples, then goes to SLOW with blk_cnt cleared.
REQ-028 HALT (speed 0): on clr_cnt == FILT it goes to SLOW.
REQ-029 In CRUISE or SLOW, a watchdog counter counts cycles since the last dist_valid.
- When it reaches WD_CYC: go to HALT and set timeout.
- The counter clears on every dist_valid and in every other state.
REQ-030 When a watchdog trip and a valid sample fall on the same cycle, the sample wins and no trip occurs.
REQ-031 Samples arriving during TURN update clr_cnt but not blk_cnt.

Reset
REQ-032 While rstn is low, all outputs and internal registers clear asynchronously.
- state = IDLE, speed = 0, turning = 0, turn_dir = 0, timeout = 0, all counters = 0.
REQ-033 Reset asserted mid-TURN or mid-HALT aborts the operation immediately.
REQ-034 Leaving reset is synchronous: the first state update happens on the first rising clk edge with rstn high.

Structure
REQ-035 A shared package robot_pkg holds:
- the state enum;
- the speed encodings;
- the default threshold constants.
REQ-036 Selection of the side channel with the largest distance is one combinational sub-module, robot_argmax, parametrised by N_SENS and DW.
REQ-037 Illegal parameters (N_SENS < 2, or D_STOP >= D_SLOW) fail at elaboration.

Verification
REQ-038 The bench covers these directed scenarios (defaults unless stated):
- Reset, then front=1000 on the first valid -> state CRUISE, speed 2 on the next cycle.
- From CRUISE, front=50 for two valids, sides (1:300, 2:700) -> TURN, turn_dir=2, turning high for exactly 8 cycles, then SLOW.
- Front=100 (equal to D_STOP) and front=400 (equal to D_SLOW) -> treated as clear and fast respectively; front=99 once then 500 -> no TURN (filter reset).
- Front blocked, sides (1:40, 2:60) -> HALT, speed 0; then two valids with front=450 -> SLOW.
- CRUISE with dist_valid held low for 64 cycles -> HALT, timeout=1; a valid on cycle 64 instead -> no trip.
- rstn dropped during cycle 3 of TURN -> all outputs 0 immediately; N_SENS=4 tie of sides 1 and 3 -> turn_dir=1.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared types and defaults for the robot navigation controller.
// State and speed encodings are fixed and visible on the robot_nav outputs.
package robot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRUISE = 3'd1,
    ST_SLOW   = 3'd2,
    ST_TURN   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] SPD_STOP = 2'd0;
  localparam logic [1:0] SPD_SLOW = 2'd1;
  localparam logic [1:0] SPD_FAST = 2'd2;

  localparam int N_SENS_DEF   = 3;
  localparam int DW_DEF       = 16;
  localparam int D_SLOW_DEF   = 400;
  localparam int D_STOP_DEF   = 100;
  localparam int FILT_DEF     = 2;
  localparam int TURN_CYC_DEF = 8;
  localparam int WD_CYC_DEF   = 64;

  function automatic logic [1:0] speed_of(input state_t s);
    case (s)
      ST_CRUISE: speed_of = SPD_FAST;
      ST_SLOW:   speed_of = SPD_SLOW;
      default:   speed_of = SPD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/robot_argmax.sv
// Picks the side channel with the largest distance, lowest index on ties.
// Purely combinational; no flow control.
module robot_argmax #(
  parameter int N_SENS = 3,
  parameter int DW     = 16,
  localparam int IW    = (N_SENS > 2) ? $clog2(N_SENS) : 1
) (
  input  logic [(N_SENS-1)*DW-1:0] side_v,
  output logic [IW-1:0]            idx,
  output logic [DW-1:0]            max_dist
);

  // side_v slot j holds sensor channel j+1; strict > keeps the lowest index on a tie
  always_comb begin
    idx      = IW'(1);
    max_dist = side_v[DW-1:0];
    for (int j = 1; j < N_SENS - 1; j++) begin
      if (side_v[j*DW +: DW] > max_dist) begin
        max_dist = side_v[j*DW +: DW];
        idx      = IW'(j + 1);
      end
    end
  end

endmodule

// File: rtl/robot_nav.sv
// Obstacle-avoidance FSM: filtered front distance drives speed, turns toward the widest side.
// Latency: outputs registered, one cycle after a dist_valid strobe; no backpressure, samples never stall.
module robot_nav
  import robot_pkg::*;
#(
  parameter int N_SENS   = N_SENS_DEF,
  parameter int DW       = DW_DEF,
  parameter int D_SLOW   = D_SLOW_DEF,
  parameter int D_STOP   = D_STOP_DEF,
  parameter int FILT     = FILT_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int WD_CYC   = WD_CYC_DEF,
  localparam int IW      = (N_SENS > 2) ? $clog2(N_SENS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_SENS*DW-1:0] dist_v,
  input  logic                 dist_valid,
  output logic [1:0]           speed,
  output logic                 turning,
  output logic [IW-1:0]        turn_dir,
  output logic [2:0]           state,
  output logic                 timeout
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int WW = $clog2(WD_CYC + 1);
  localparam logic [DW-1:0] STOP_TH = DW'(D_STOP);
  localparam logic [DW-1:0] SLOW_TH = DW'(D_SLOW);

  generate
    if (N_SENS < 2 || N_SENS > 8 || D_STOP >= D_SLOW || FILT < 1 || TURN_CYC < 1 || WD_CYC < 1) begin : g_bad_params
      $error("robot_nav: illegal parameter combination");
    end
  endgenerate

  state_t         st_q, st_d;
  logic [FW-1:0]  blk_q, blk_d, clr_q, clr_d;
  logic [TW-1:0]  turn_q, turn_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [IW-1:0]  dir_d;
  logic           to_d;
  logic           enter_turn;
  logic [IW-1:0]  side_idx;
  logic [DW-1:0]  side_max;
  logic [DW-1:0]  front;
  logic           f_blk, f_slow;

  assign front  = dist_v[DW-1:0];
  assign f_blk  = front < STOP_TH;
  assign f_slow = front < SLOW_TH;

  robot_argmax #(.N_SENS(N_SENS), .DW(DW)) u_argmax (
    .side_v   (dist_v[N_SENS*DW-1:DW]),
    .idx      (side_idx),
    .max_dist (side_max)
  );

  always_comb begin
    st_d       = st_q;
    blk_d      = blk_q;
    clr_d      = clr_q;
    turn_d     = '0;
    wd_d       = '0;
    dir_d      = turn_dir;
    to_d       = timeout;
    enter_turn = 1'b0;

    // Filters advance on the sample itself, so a confirming sample acts this cycle
    if (dist_valid) begin
      clr_d = f_slow ? '0 : ((clr_q == FW'(FILT)) ? clr_q : clr_q + FW'(1));
      if (st_q != ST_TURN)
        blk_d = !f_blk ? '0 : ((blk_q == FW'(FILT)) ? blk_q : blk_q + FW'(1));
    end

    case (st_q)
      ST_IDLE: begin
        if (dist_valid) begin
          if (f_blk)       enter_turn = 1'b1;
          else if (f_slow) st_d = ST_SLOW;
          else             st_d = ST_CRUISE;
        end
      end
      ST_CRUISE, ST_SLOW: begin
        if (dist_valid) begin
          if (blk_d == FW'(FILT))              enter_turn = 1'b1;
          else if (st_q == ST_CRUISE && f_slow)  st_d = ST_SLOW;
          else if (st_q == ST_SLOW && !f_slow)   st_d = ST_CRUISE;
        end else if (wd_q + WW'(1) == WW'(WD_CYC)) begin
          st_d = ST_HALT;
          to_d = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      ST_TURN: begin
        if (turn_q == TW'(TURN_CYC - 1)) begin
          st_d  = ST_SLOW;
          blk_d = '0;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      ST_HALT: begin
        if (dist_valid && clr_d == FW'(FILT)) st_d = ST_SLOW;
      end
      default: st_d = ST_IDLE;
    endcase

    // No open side: stop in place instead of turning
    if (enter_turn) begin
      if (side_max < STOP_TH) begin
        st_d = ST_HALT;
      end else begin
        st_d  = ST_TURN;
        dir_d = side_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= ST_IDLE;
      blk_q    <= '0;
      clr_q    <= '0;
      turn_q   <= '0;
      wd_q     <= '0;
      speed    <= SPD_STOP;
      turning  <= 1'b0;
      turn_dir <= '0;
      timeout  <= 1'b0;
    end else begin
      st_q     <= st_d;
      blk_q    <= blk_d;
      clr_q    <= clr_d;
      turn_q   <= turn_d;
      wd_q     <= wd_d;
      speed    <= speed_of(st_d);
      turning  <= (st_d == ST_TURN);
      turn_dir <= dir_d;
      timeout  <= to_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_robot_nav.sv
// Bench for robot_nav: default 3-channel instance plus a 4-channel instance for the tie case.
module tb_robot_nav;
  import robot_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [47:0] dv3;
  logic        vld3;
  logic [1:0]  spd3;
  logic        trn3;
  logic [1:0]  dir3;
  logic [2:0]  st3;
  logic        to3;

  logic [63:0] dv4;
  logic        vld4;
  logic [1:0]  spd4;
  logic        trn4;
  logic [1:0]  dir4;
  logic [2:0]  st4;
  logic        to4;

  robot_nav dut3 (
    .clk(clk), .rstn(rstn), .dist_v(dv3), .dist_valid(vld3),
    .speed(spd3), .turning(trn3), .turn_dir(dir3), .state(st3), .timeout(to3)
  );

  robot_nav #(.N_SENS(4)) dut4 (
    .clk(clk), .rstn(rstn), .dist_v(dv4), .dist_valid(vld4),
    .speed(spd4), .turning(trn4), .turn_dir(dir4), .state(st4), .timeout(to4)
  );

  typedef struct {
    string      name;
    bit         sel;
    logic [8:0] exp;
  } exp_t;

  typedef struct {
    string      name;
    logic       v;
    int         f;
    int         s1;
    int         s2;
    logic [2:0] st;
    logic [1:0] sp;
    logic       tr;
    logic [1:0] dir;
    logic       to;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [8:0] pack_exp(input logic [2:0] st, input logic [1:0] sp,
                                          input logic tr, input logic [1:0] dir, input logic to);
    return {st, sp, tr, dir, to};
  endfunction

  function automatic logic [8:0] obs3();
    return {st3, spd3, trn3, dir3, to3};
  endfunction

  function automatic logic [8:0] obs4();
    return {st4, spd4, trn4, dir4, to4};
  endfunction

  task automatic compare(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d speed=%0d turning=%0b dir=%0d timeout=%0b, expected state=%0d speed=%0d turning=%0b dir=%0d timeout=%0b",
               name, got[8:6], got[5:4], got[3], got[2:1], got[0],
               exp[8:6], exp[5:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = sb.pop_front();
      compare(e.name, e.sel ? obs4() : obs3(), e.exp);
    end
  endtask

  // One cycle: drive at negedge, queue the expectation, compare after the edge
  task automatic drive(input string name, input bit sel, input logic v,
                       input int f, input int s1, input int s2, input int s3,
                       input logic [8:0] exp);
    @(negedge clk);
    if (sel) begin
      dv4  = {16'(s3), 16'(s2), 16'(s1), 16'(f)};
      vld4 = v;
    end else begin
      dv3  = {16'(s2), 16'(s1), 16'(f)};
      vld3 = v;
    end
    sb.push_back('{name, sel, exp});
    @(posedge clk);
    #1;
    vld3 = 1'b0;
    vld4 = 1'b0;
    check_sb();
  endtask

  task automatic add(input string n, input logic v, input int f, input int s1, input int s2,
                     input logic [2:0] st, input logic [1:0] sp, input logic tr,
                     input logic [1:0] dir, input logic to);
    tbl.push_back('{n, v, f, s1, s2, st, sp, tr, dir, to});
  endtask

  initial begin
    dv3 = '0; vld3 = 1'b0;
    dv4 = '0; vld4 = 1'b0;

    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare("reset3", obs3(), 9'd0);
    compare("reset4", obs4(), 9'd0);
    @(negedge clk) rstn = 1'b1;

    add("first_fast",    1, 1000,   0,   0, ST_CRUISE, SPD_FAST, 0, 0, 0);
    add("front_eq_stop", 1,  100,   0,   0, ST_SLOW,   SPD_SLOW, 0, 0, 0);
    add("front_eq_slow", 1,  400,   0,   0, ST_CRUISE, SPD_FAST, 0, 0, 0);
    add("blk_once",      1,   99,   0,   0, ST_SLOW,   SPD_SLOW, 0, 0, 0);
    add("clear_after",   1,  500,   0,   0, ST_CRUISE, SPD_FAST, 0, 0, 0);
    add("filt_reset",    1,   50, 300, 700, ST_SLOW,   SPD_SLOW, 0, 0, 0);
    add("turn_entry",    1,   50, 300, 700, ST_TURN,   SPD_STOP, 1, 2, 0);
    for (int i = 0; i < 7; i++)
      add("turn_hold",   1,   50, 300, 700, ST_TURN,   SPD_STOP, 1, 2, 0);
    add("turn_exit",     0,    0,   0,   0, ST_SLOW,   SPD_SLOW, 0, 2, 0);
    add("blk_cleared",   1,   50,  40,  60, ST_SLOW,   SPD_SLOW, 0, 2, 0);
    add("halt_entry",    1,   50,  40,  60, ST_HALT,   SPD_STOP, 0, 2, 0);
    add("halt_clr1",     1,  450,  40,  60, ST_HALT,   SPD_STOP, 0, 2, 0);
    add("halt_idle",     0,    0,   0,   0, ST_HALT,   SPD_STOP, 0, 2, 0);
    add("halt_exit",     1,  450,  40,  60, ST_SLOW,   SPD_SLOW, 0, 2, 0);
    add("slow_fast",     1,  450,  40,  60, ST_CRUISE, SPD_FAST, 0, 2, 0);

    foreach (tbl[i])
      drive(tbl[i].name, 1'b0, tbl[i].v, tbl[i].f, tbl[i].s1, tbl[i].s2, 0,
            pack_exp(tbl[i].st, tbl[i].sp, tbl[i].tr, tbl[i].dir, tbl[i].to));

    // Watchdog: a sample on the 64th quiet cycle wins, a 64th quiet cycle trips
    for (int i = 0; i < 63; i++)
      drive("wd_wait_a", 0, 0, 0, 0, 0, 0, pack_exp(ST_CRUISE, SPD_FAST, 0, 2, 0));
    drive("wd_sample_wins", 0, 1, 1000, 0, 0, 0, pack_exp(ST_CRUISE, SPD_FAST, 0, 2, 0));
    for (int i = 0; i < 63; i++)
      drive("wd_wait_b", 0, 0, 0, 0, 0, 0, pack_exp(ST_CRUISE, SPD_FAST, 0, 2, 0));
    drive("wd_trip", 0, 0, 0, 0, 0, 0, pack_exp(ST_HALT, SPD_STOP, 0, 2, 1));
    // clr_cnt already saturated by the earlier clear samples, so one more exits HALT
    drive("tmo_sticky_slow",   0, 1, 450, 0, 0, 0, pack_exp(ST_SLOW,   SPD_SLOW, 0, 2, 1));
    drive("tmo_sticky_cruise", 0, 1, 450, 0, 0, 0, pack_exp(ST_CRUISE, SPD_FAST, 0, 2, 1));

    // Reset in the middle of TURN
    drive("pre_turn",  0, 1, 50, 700, 300, 0, pack_exp(ST_SLOW, SPD_SLOW, 0, 2, 1));
    drive("turn_c1",   0, 1, 50, 700, 300, 0, pack_exp(ST_TURN, SPD_STOP, 1, 1, 1));
    drive("turn_c2",   0, 0,  0,   0,   0, 0, pack_exp(ST_TURN, SPD_STOP, 1, 1, 1));
    drive("turn_c3",   0, 0,  0,   0,   0, 0, pack_exp(ST_TURN, SPD_STOP, 1, 1, 1));
    #2 rstn = 1'b0;
    #1;
    compare("async_reset", obs3(), 9'd0);
    dv3  = {16'd0, 16'd0, 16'd1000};
    vld3 = 1'b1;
    @(posedge clk);
    #1;
    compare("reset_hold", obs3(), 9'd0);
    @(negedge clk);
    vld3 = 1'b0;
    rstn = 1'b1;
    drive("post_reset", 0, 1, 1000, 0, 0, 0, pack_exp(ST_CRUISE, SPD_FAST, 0, 0, 0));

    // Four channels: IDLE turns on the first blocked sample, tie between sides 1 and 3
    drive("n4_tie_turn", 1, 1, 50, 500, 200, 500, pack_exp(ST_TURN, SPD_STOP, 1, 1, 0));
    for (int i = 0; i < 7; i++)
      drive("n4_turn_hold", 1, 0, 0, 0, 0, 0, pack_exp(ST_TURN, SPD_STOP, 1, 1, 0));
    drive("n4_turn_exit", 1, 0, 0, 0, 0, 0, pack_exp(ST_SLOW, SPD_SLOW, 0, 1, 0));

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
